// File: rtl/sps_pkg.sv
// rtl/sps_pkg.sv - shared state encoding and limits for slow_pulse_scheduler
package sps_pkg;

  typedef enum logic [1:0] {
    SPS_IDLE  = 2'd0,
    SPS_OFFER = 2'd1,
    SPS_GAP   = 2'd2
  } sps_state_e;

  localparam int SPS_OVR_W   = 8;
  localparam int SPS_MAX_REQ = 16;
  localparam int SPS_GAP_W   = 8;

endpackage

// File: rtl/req_edge_sync.sv
// rtl/req_edge_sync.sv - 2-flop synchronizer plus history flop, rising-edge detect
module req_edge_sync (
  input  logic slowClock,
  input  logic reset,
  input  logic req_in,
  output logic rise
);

  logic stage1_q, stage1_d;
  logic stage2_q, stage2_d;
  logic hist_q, hist_d;

  always_comb begin
    stage1_d = req_in;
    stage2_d = stage1_q;
    hist_d   = stage2_q;
  end

  // Clearing history on reset makes a line held high across reset count once.
  always_ff @(posedge slowClock) begin
    if (!reset) begin
      stage1_q <= 1'b0;
      stage2_q <= 1'b0;
      hist_q   <= 1'b0;
    end else begin
      stage1_q <= stage1_d;
      stage2_q <= stage2_d;
      hist_q   <= hist_d;
    end
  end

  assign rise = stage2_q & ~hist_q;

endmodule

// File: rtl/slow_pulse_scheduler.sv
// rtl/slow_pulse_scheduler.sv - round-robin grant scheduler for synchronized event pulses
// Optional per-requester overrun counters are built when SPS_OVERRUN_EN is defined.
module slow_pulse_scheduler
  import sps_pkg::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int GAP_CYCLES = 2,
  localparam int IDX_W      = $clog2(N_REQ)
) (
  input  logic                       slowClock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           reqIn,
  output logic                       grantValid,
  output logic [IDX_W-1:0]           grantIndex,
  input  logic                       grantReady,
  output logic                       busy,
  output logic [N_REQ-1:0]           pendingOut
`ifdef SPS_OVERRUN_EN
  ,
  output logic [SPS_OVR_W*N_REQ-1:0] overrunCount
`endif
);

  if (N_REQ < 2 || N_REQ > SPS_MAX_REQ) begin : g_bad_nreq
    $error("slow_pulse_scheduler: N_REQ out of range");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_bad_gap
    $error("slow_pulse_scheduler: GAP_CYCLES out of range");
  end

  localparam logic [SPS_GAP_W-1:0] GAP_LOAD =
      (GAP_CYCLES == 0) ? '0 : SPS_GAP_W'(GAP_CYCLES - 1);

  logic [N_REQ-1:0] rise;

  for (genvar g = 0; g < N_REQ; g++) begin : g_sync
    req_edge_sync u_sync (
      .slowClock (slowClock),
      .reset     (reset),
      .req_in    (reqIn[g]),
      .rise      (rise[g])
    );
  end

  sps_state_e             state_q, state_d;
  logic                   grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]       grant_index_q, grant_index_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [SPS_GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [N_REQ-1:0]       pending_q, pending_d;

  logic                   transfer;
  logic [N_REQ-1:0]       clear_vec;
  logic [IDX_W-1:0]       arb_win;

  assign transfer = grant_valid_q & grantReady;

  always_comb begin
    clear_vec = '0;
    if (transfer) begin
      clear_vec[grant_index_q] = 1'b1;
    end
    // Set after clear so a new edge on the granted bit survives the transfer.
    pending_d = (pending_q & ~clear_vec) | rise;
  end

  always_comb begin : arb
    int   idx;
    logic found;
    arb_win = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!found && pending_q[idx]) begin
        found   = 1'b1;
        arb_win = idx[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_index_d = grant_index_q;
    rr_ptr_d      = rr_ptr_q;
    gap_cnt_d     = gap_cnt_q;
    case (state_q)
      SPS_IDLE: begin
        if (|pending_q) begin
          state_d       = SPS_OFFER;
          grant_index_d = arb_win;
        end
      end
      SPS_OFFER: begin
        if (transfer) begin
          rr_ptr_d = (grant_index_q == IDX_W'(N_REQ - 1)) ? '0
                                                          : grant_index_q + IDX_W'(1);
          if (GAP_CYCLES == 0) begin
            state_d = SPS_IDLE;
          end else begin
            state_d   = SPS_GAP;
            gap_cnt_d = GAP_LOAD;
          end
        end
      end
      SPS_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = SPS_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - SPS_GAP_W'(1);
        end
      end
      default: state_d = SPS_IDLE;
    endcase
    grant_valid_d = (state_d == SPS_OFFER);
  end

  always_ff @(posedge slowClock) begin
    if (!reset) begin
      state_q       <= SPS_IDLE;
      grant_valid_q <= 1'b0;
      grant_index_q <= '0;
      rr_ptr_q      <= '0;
      gap_cnt_q     <= '0;
      pending_q     <= '0;
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_index_q <= grant_index_d;
      rr_ptr_q      <= rr_ptr_d;
      gap_cnt_q     <= gap_cnt_d;
      pending_q     <= pending_d;
    end
  end

  assign grantValid = grant_valid_q;
  assign grantIndex = grant_index_q;
  assign busy       = (state_q != SPS_IDLE);
  assign pendingOut = pending_q;

`ifdef SPS_OVERRUN_EN
  logic [SPS_OVR_W-1:0] ovr_q [N_REQ];
  logic [SPS_OVR_W-1:0] ovr_d [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      ovr_d[i] = ovr_q[i];
      if (rise[i] && pending_q[i] && !clear_vec[i] && (ovr_q[i] != '1)) begin
        ovr_d[i] = ovr_q[i] + SPS_OVR_W'(1);
      end
    end
  end

  always_ff @(posedge slowClock) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (!reset) begin
        ovr_q[i] <= '0;
      end else begin
        ovr_q[i] <= ovr_d[i];
      end
    end
  end

  always_comb begin
    overrunCount = '0;
    for (int i = 0; i < N_REQ; i++) begin
      overrunCount[SPS_OVR_W*i +: SPS_OVR_W] = ovr_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_slow_pulse_scheduler.sv
// tb/tb_slow_pulse_scheduler.sv - directed self-checking bench for slow_pulse_scheduler
module tb_slow_pulse_scheduler;

  logic       slowClock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] reqIn = 4'b0;
  logic       grantReady = 1'b0;
  logic       grantValid;
  logic [1:0] grantIndex;
  logic       busy;
  logic [3:0] pendingOut;
`ifdef SPS_OVERRUN_EN
  logic [31:0] overrunCount;
`endif

  slow_pulse_scheduler #(.N_REQ(4), .GAP_CYCLES(2)) dut (
    .slowClock    (slowClock),
    .reset        (reset),
    .reqIn        (reqIn),
    .grantValid   (grantValid),
    .grantIndex   (grantIndex),
    .grantReady   (grantReady),
    .busy         (busy),
    .pendingOut   (pendingOut)
`ifdef SPS_OVERRUN_EN
    ,
    .overrunCount (overrunCount)
`endif
  );

  always #5 slowClock = ~slowClock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge slowClock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge slowClock);
  endtask

  task automatic pulse(input logic [3:0] m);
    reqIn = reqIn | m;
    tick(2);
    reqIn = reqIn & ~m;
  endtask

  task automatic wait_grant(input string tag, input int exp_idx, output int at);
    int n;
    n = 0;
    while (grantValid !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 50), 32'd1);
    check({tag, "_idx"}, 32'(grantIndex), 32'(exp_idx));
    at = cyc;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int c [4];
    int seen;

    tick(3);
    check("rst_valid", 32'(grantValid), 32'd0);
    check("rst_index", 32'(grantIndex), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pending", 32'(pendingOut), 32'd0);
`ifdef SPS_OVERRUN_EN
    check("rst_ovr", overrunCount, 32'd0);
`endif
    reset = 1'b1;
    grantReady = 1'b1;
    tick(2);

    // fairness: all four lines at once
    t0 = cyc;
    pulse(4'b1111);
    wait_grant("fair0", 0, c[0]);
    check("fair0_latency", 32'(c[0] - t0), 32'd4);
    for (int i = 1; i < 4; i++) begin
      tick(1);
      wait_grant("fair_n", i, c[i]);
      check("fair_spacing", 32'(c[i] - c[i-1]), 32'd4);
    end
    tick(1);
    pulse(4'b1001);
    wait_grant("wrap_a", 0, c[0]);
    tick(1);
    wait_grant("wrap_b", 3, c[1]);
    check("wrap_spacing", 32'(c[1] - c[0]), 32'd4);
    tick(1);

    // single event on line 2
    tick(6);
    check("se_idle", 32'(busy), 32'd0);
    t0 = cyc;
    pulse(4'b0100);
    check("se_k1_valid", 32'(grantValid), 32'd0);
    check("se_k1_pending", 32'(pendingOut), 32'd0);
    tick(1);
    check("se_k2_pending", 32'(pendingOut), 32'b0100);
    check("se_k2_valid", 32'(grantValid), 32'd0);
    tick(1);
    check("se_k3_valid", 32'(grantValid), 32'd1);
    check("se_k3_index", 32'(grantIndex), 32'd2);
    check("se_k3_cycle", 32'(cyc - t0), 32'd4);
    tick(1);
    check("se_k4_valid", 32'(grantValid), 32'd0);
    check("se_k4_pending", 32'(pendingOut), 32'd0);
    check("se_k4_busy", 32'(busy), 32'd1);
    tick(2);
    check("se_end_busy", 32'(busy), 32'd0);
    tick(5);
    check("se_no_regrant", 32'(grantValid), 32'd0);

    // backpressure on line 1
    grantReady = 1'b0;
    pulse(4'b0010);
    wait_grant("bp", 1, c[0]);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("bp_valid", 32'(grantValid), 32'd1);
      check("bp_index", 32'(grantIndex), 32'd1);
    end
    grantReady = 1'b1;
    tick(1);
    check("bp_done_valid", 32'(grantValid), 32'd0);
    check("bp_done_pending", 32'(pendingOut), 32'd0);

    // set and clear of pending[1] on the same edge
    grantReady = 1'b0;
    tick(4);
    pulse(4'b0010);
    wait_grant("col_a", 1, c[0]);
    tick(3);
    reqIn = 4'b0010;
    tick(2);
    reqIn = 4'b0000;
    grantReady = 1'b1;
    tick(1);
    check("col_valid", 32'(grantValid), 32'd0);
    check("col_pending", 32'(pendingOut), 32'b0010);
    wait_grant("col_b", 1, c[1]);
    tick(1);
    check("col_b_pending", 32'(pendingOut), 32'd0);

    // repeated events on line 0 while its offer is stalled
    grantReady = 1'b0;
    tick(4);
    for (int i = 0; i < 300; i++) begin
      pulse(4'b0001);
      tick(2);
    end
    tick(2);
    check("ovr_valid", 32'(grantValid), 32'd1);
    check("ovr_index", 32'(grantIndex), 32'd0);
    check("ovr_pending", 32'(pendingOut), 32'b0001);
`ifdef SPS_OVERRUN_EN
    check("ovr_count0", 32'(overrunCount[7:0]), 32'hFF);
    check("ovr_count_rest", 32'(overrunCount[31:8]), 32'd0);
`endif
    grantReady = 1'b1;
    tick(1);
    check("ovr_done_valid", 32'(grantValid), 32'd0);
    check("ovr_done_pending", 32'(pendingOut), 32'd0);
    tick(10);
    check("ovr_single_grant", 32'(grantValid), 32'd0);

    // reset while offering
    grantReady = 1'b0;
    pulse(4'b1000);
    wait_grant("rmo", 3, c[0]);
    reset = 1'b0;
    tick(1);
    check("rmo_valid", 32'(grantValid), 32'd0);
    check("rmo_index", 32'(grantIndex), 32'd0);
    check("rmo_busy", 32'(busy), 32'd0);
    check("rmo_pending", 32'(pendingOut), 32'd0);
`ifdef SPS_OVERRUN_EN
    check("rmo_ovr", overrunCount, 32'd0);
`endif
    reset = 1'b1;
    grantReady = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (grantValid === 1'b1) seen = 1;
    end
    check("rmo_no_grant", 32'(seen), 32'd0);
    pulse(4'b0101);
    wait_grant("rmo_after_a", 0, c[0]);
    tick(1);
    wait_grant("rmo_after_b", 2, c[1]);
    tick(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
